// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between two writeback requesters,
// with a per-register busy scoreboard for decode. Define RF_ARB_FWD_EN to add same-cycle forwarding.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned RST_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] rd1_reg,
    input  logic [ADDR_W-1:0] rd2_reg,
    output logic              rd1_busy,
    output logic              rd2_busy,
`ifdef RF_ARB_FWD_EN
    output logic              rd1_fwd,
    output logic              rd2_fwd,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              regwrite,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] writeda
);

    localparam logic [0:0] PRI0 = 1'b0;
    localparam logic [0:0] PRI1 = 1'b1;

    logic [0:0]        pri_q, pri_d;
    logic              gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0] gnt_reg;
    logic [DATA_W-1:0] gnt_data;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] writereg_q, writereg_d;
    logic [DATA_W-1:0] writeda_q, writeda_d;
    logic              hit_rd1, hit_rd2, hit_issue;

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pri_d = pri_q;
        if (req0_valid && req1_valid) begin
            if (pri_q == PRI0) begin
                gnt0  = 1'b1;
                pri_d = PRI1;
            end else begin
                gnt1  = 1'b1;
                pri_d = PRI0;
            end
        end else if (req0_valid) begin
            gnt0  = 1'b1;
            pri_d = PRI1;
        end else if (req1_valid) begin
            gnt1  = 1'b1;
            pri_d = PRI0;
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign gnt_reg  = gnt1 ? req1_reg : req0_reg;
    assign gnt_data = gnt1 ? req1_data : req0_data;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

`ifdef RF_ARB_FWD_EN
    // A write granted this cycle satisfies readers of the same register immediately.
    assign hit_rd1   = gnt_any && (rd1_reg != '0) && (gnt_reg == rd1_reg);
    assign hit_rd2   = gnt_any && (rd2_reg != '0) && (gnt_reg == rd2_reg);
    assign hit_issue = gnt_any && (gnt_reg == issue_reg);
    assign rd1_fwd   = hit_rd1;
    assign rd2_fwd   = hit_rd2;
    assign fwd_data  = gnt_data;
`else
    assign hit_rd1   = 1'b0;
    assign hit_rd2   = 1'b0;
    assign hit_issue = 1'b0;
`endif

    assign issue_stall = issue_valid && busy_q[issue_reg] && (issue_reg != '0) && !hit_issue;
    assign rd1_busy    = busy_q[rd1_reg] && (rd1_reg != '0) && !hit_rd1;
    assign rd2_busy    = busy_q[rd2_reg] && (rd2_reg != '0) && !hit_rd2;

    // Clear first so that a same-cycle issue to the same register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[gnt_reg] = 1'b0;
        end
        if (issue_valid && !issue_stall && (issue_reg != '0)) begin
            busy_d[issue_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        regwrite_d = gnt_any && (gnt_reg != '0);
        writereg_d = regwrite_d ? gnt_reg : writereg_q;
        writeda_d  = regwrite_d ? gnt_data : writeda_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q      <= (RST_PRI != 0) ? PRI1 : PRI0;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            writereg_q <= '0;
            writeda_q  <= '0;
        end else begin
            pri_q      <= pri_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            writereg_q <= writereg_d;
            writeda_q  <= writeda_d;
        end
    end

    assign regwrite = regwrite_q;
    assign writereg = writereg_q;
    assign writeda  = writeda_q;

endmodule
